// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ready + rvalid handshake and
// computes the next PC from decoder/datapath inputs when the instruction commits.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct,
  output logic        instr_valid,
  input  logic        commit,
  input  logic        cntl_Branch,
  input  logic        branch_taken,
  input  logic [1:0]  sel_jump,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_addr,
  output logic        fetch_fault
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [2:0] {StBoot, StReq, StWait, StExec, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic [31:0] jalr_sum;

  assign pc_plus4    = pc_q + 32'd4;
  assign branch_addr = pc_q + imm;
  assign jalr_sum    = rs1_data + imm;

  // Jumps take priority over a conditional branch flagged in the same cycle.
  always_comb begin
    next_pc = pc_plus4;
    unique case (sel_jump)
      2'b10:   next_pc = branch_addr;
      2'b01:   next_pc = {jalr_sum[31:1], 1'b0};
      2'b00:   next_pc = (cntl_Branch && branch_taken) ? branch_addr : pc_plus4;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (imem_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (commit) begin
          if (sel_jump == 2'b11) begin
            state_d = StFault;
          end else begin
            // A misaligned target is still latched so it is visible for debug.
            pc_d    = next_pc;
            state_d = (next_pc[1:0] != 2'b00) ? StFault : StReq;
          end
        end
      end
      StFault: state_d = StFault;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= Nop;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StExec);
  assign fetch_fault = (state_q == StFault);
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign funct       = instr_q[14:12];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: handshake timing, next-PC selection,
// fault behaviour and mid-fetch reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        instr_valid;
  logic        commit = 1'b0;
  logic        cntl_Branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic [1:0]  sel_jump = 2'b00;
  logic [31:0] imm = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_addr;
  logic        fetch_fault;

  int unsigned total = 0;
  int unsigned passed = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .commit      (commit),
    .cntl_Branch (cntl_Branch),
    .branch_taken(branch_taken),
    .sel_jump    (sel_jump),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .branch_addr (branch_addr),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
  endtask

  // Serve one fetch with the given ready/rvalid wait states, checking the request side.
  task automatic fetch(input string tag, input int ready_wait, input int rvalid_wait,
                       input logic [31:0] data, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
    for (int i = 0; i < ready_wait; i++) begin
      tick();
      chk({tag, "_hold"}, {imem_req, imem_addr[30:0]}, {1'b1, exp_addr[30:0]});
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk({tag, "_req_drop"}, {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < rvalid_wait; i++) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, instr, data);
  endtask

  task automatic do_commit(input logic [1:0] sj, input logic br, input logic tk,
                           input logic [31:0] im, input logic [31:0] rs1);
    sel_jump     = sj;
    cntl_Branch  = br;
    branch_taken = tk;
    imm          = im;
    rs1_data     = rs1;
    commit       = 1'b1;
    tick();
    commit       = 1'b0;
    sel_jump     = 2'b00;
    cntl_Branch  = 1'b0;
    branch_taken = 1'b0;
    imm          = 32'h0;
    rs1_data     = 32'h0;
  endtask

  initial begin
    // 1: reset and first fetch
    #12;
    chk_reset_vals("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("boot_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    fetch("t1", 0, 0, 32'h0050_0093, 32'h0);
    chk("t1_opcode", {25'b0, opcode}, 32'b0010011);
    chk("t1_funct", {29'b0, funct}, 32'd0);
    // Instruction must hold through EXEC regardless of memory inputs.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("t1_stable", instr, 32'h0050_0093);

    // 2: sequential with wait states
    do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch("t2", 3, 2, 32'h0000_0013, 32'h4);
    do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch("t2b", 0, 0, 32'h0000_0013, 32'h8);
    chk("t2_plus4", pc_plus4, 32'hC);

    // 3: branches from pc=0x100
    do_commit(2'b10, 1'b0, 1'b0, 32'h0000_00F8, 32'h0);
    fetch("t3_to100", 0, 0, 32'h0000_0063, 32'h100);
    imm = 32'hFFFF_FFF8;
    #1 chk("t3_baddr", branch_addr, 32'hF8);
    do_commit(2'b00, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0);
    fetch("t3_taken", 0, 1, 32'h0000_006F, 32'hF8);
    do_commit(2'b10, 1'b0, 1'b0, 32'h8, 32'h0);
    fetch("t3_back", 0, 0, 32'h0000_0063, 32'h100);
    do_commit(2'b00, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    fetch("t3_ntaken", 0, 0, 32'h0000_0013, 32'h104);
    do_commit(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    fetch("t3_back2", 0, 0, 32'h0000_0063, 32'h100);
    do_commit(2'b10, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0);
    fetch("t3_jwins", 0, 0, 32'h0000_0067, 32'hF8);

    // 4: JALR bit0 clear, then misaligned target faults
    do_commit(2'b01, 1'b0, 1'b0, 32'h3, 32'h2001);
    fetch("t4_ok", 0, 0, 32'h0000_0067, 32'h2004);
    do_commit(2'b01, 1'b0, 1'b0, 32'h2, 32'h2001);
    chk("t4_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t4_pc", pc, 32'h2002);
    commit = 1'b1;
    repeat (3) tick();
    commit = 1'b0;
    chk("t4_sticky", {29'b0, fetch_fault, imem_req, instr_valid}, 32'b100);
    chk("t4_frozen", pc, 32'h2002);

    // 5: reset mid-WAIT, stale rvalid after release
    rst_n = 1'b0;
    #1 chk_reset_vals("t5a");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("t5_wait", {30'b0, imem_req, instr_valid}, 32'b00);
    rst_n = 1'b0;
    #1 chk_reset_vals("t5b");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk("t5_nop", instr, 32'h0000_0013);
    chk("t5_novalid", {31'b0, instr_valid}, 32'd0);
    fetch("t5_fresh", 0, 0, 32'h0000_0013, 32'h0);

    // 6: PC wraparound and illegal sel_jump
    do_commit(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    fetch("t6_top", 0, 0, 32'h0000_0013, 32'hFFFF_FFFC);
    chk("t6_plus4", pc_plus4, 32'h0);
    do_commit(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_nofault", {31'b0, fetch_fault}, 32'd0);
    fetch("t6_wrap", 0, 0, 32'h0000_0013, 32'h0);
    do_commit(2'b11, 1'b0, 1'b0, 32'h40, 32'h0);
    chk("t6_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t6_pc", pc, 32'h0);
    imem_ready = 1'b1;
    repeat (3) tick();
    imem_ready = 1'b0;
    chk("t6_noreq", {31'b0, imem_req}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
